seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/shift_add_mul.sv | 68 ++++++
 rtl/seq_alu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcode constants for the single-cycle ALU and the
// state encoding of the sequential wrapper.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for every opcode the single-cycle datapath resolves by itself.
  function automatic logic is_single_cycle_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SLTU, OP_SUB, OP_SLT, OP_NOR: legal = 1'b1;
      default:                                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b in
// exactly WIDTH steps after i_start; o_done marks the final step's cycle.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_product,
  output logic             o_done
);

  localparam int              CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_acc_nxt;

  // Accumulator value after the current step; the product is taken from here
  // on the last step so the parent can capture it on the same edge.
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mplier[0]) begin
      w_acc_nxt = r_acc + r_mcand;
    end else begin
      w_acc_nxt = r_acc;
    end
  end

  // Operand copies, accumulator and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == LAST_STEP) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= 1'b1;
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign o_done    = r_busy && (r_cnt == LAST_STEP);
  assign o_product = w_acc_nxt;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops finish in one
// cycle, multiply runs on the iterative shift-add unit.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_err;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic             w_alu_err;

  assign w_accept    = in_valid && (r_state == ST_IDLE);
  assign w_is_mul    = (control == OP_MUL) && (MUL_EN != 0);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_sum       = a + b;
  assign w_diff      = a - b;

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (a),
    .i_b       (b),
    .o_product (w_product),
    .o_done    (w_mul_done)
  );

  // Single-cycle datapath; illegal opcodes (and mul when disabled) give 0 with err.
  always_comb begin
    w_alu_res = {WIDTH{1'b0}};
    w_alu_ovf = 1'b0;
    w_alu_err = !is_single_cycle_op(control);
    case (control)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_NOR:  w_alu_res = ~(a | b);
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: w_alu_res = {WIDTH{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_mul_done) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result registers: loaded once per operation and held until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= {WIDTH{1'b0}};
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_alu_res;
      r_zero   <= (w_alu_res == {WIDTH{1'b0}});
      r_ovf    <= w_alu_ovf;
      r_err    <= w_alu_err;
    end else if ((r_state == ST_BUSY) && w_mul_done) begin
      r_result <= w_product;
      r_zero   <= (w_product == {WIDTH{1'b0}});
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_result <= r_result;
      r_zero   <= r_zero;
      r_ovf    <= r_ovf;
      r_err    <= r_err;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign err       = r_err;

endmodule
